// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: operation codes,
// default busy durations and the FSM state encoding.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Operations that occupy the unit for multiple cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath fed by the latched operands.
// Signed division is done on magnitudes so the most-negative / -1 case
// stays well defined (quotient wraps to 0x80000000, remainder 0).
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Product, quotient/remainder and divide-by-zero flag.
  always_comb begin
    div_zero = (b == 32'd0);

    if (op == MD_MULT)
      prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else
      prod = {32'd0, a} * {32'd0, b};

    neg_a = (op == MD_DIV) && a[31];
    neg_b = (op == MD_DIV) && b[31];
    a_mag = neg_a ? (32'd0 - a) : a;
    b_mag = neg_b ? (32'd0 - b) : b;

    q_mag = '0;
    r_mag = '0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end

    quot = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem  = neg_a ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO multiply/divide scheduler: accepts an op from EX, holds the unit
// busy for a fixed number of cycles, then writes HI/LO and pulses done.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | unit free; mult/div starts accepted, mthi/mtlo write now
//   ST_BUSY | counting down; HI/LO written at the edge where cnt == 1
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_Ex,
  input  logic [2:0]  mdOp_Ex,
  input  logic [31:0] rs_Ex,
  input  logic [31:0] rt_Ex,
  input  logic        useMd_Id,
  output logic        busy,
  output logic        stall_Id,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [31:0]       rs_q;
  logic [31:0]       rt_q;

  logic [63:0]       prod;
  logic [31:0]       quot;
  logic [31:0]       rem;
  logic              div_zero;

  md_alu u_alu (
    .op       (op_q),
    .a        (rs_q),
    .b        (rt_q),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  assign busy = (state == ST_BUSY);

  // ID stalls while the unit is occupied, or is about to be, and ID needs HI/LO.
  assign stall_Id = (busy | (start_Ex & is_muldiv(mdOp_Ex))) & useMd_Id;

  // FSM, down-counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_Ex) begin
            if (is_muldiv(mdOp_Ex)) begin
              op_q  <= mdOp_Ex;
              rs_q  <= rs_Ex;
              rt_q  <= rt_Ex;
              cnt   <= is_div(mdOp_Ex) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state <= ST_BUSY;
            end else if (mdOp_Ex == MD_MTHI) begin
              hi <= rs_Ex;
            end else if (mdOp_Ex == MD_MTLO) begin
              lo <= rs_Ex;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            if (is_div(op_q)) begin
              // A zero divisor still burns the full latency but keeps HI/LO.
              if (!div_zero) begin
                hi <= rem;
                lo <= quot;
              end
            end else begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Randomized self-checking bench for md_scheduler against an arithmetic
// reference model of HI/LO built on 64-bit integer operations.
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_Ex;
  logic [2:0]  mdOp_Ex;
  logic [31:0] rs_Ex;
  logic [31:0] rt_Ex;
  logic        useMd_Id;
  logic        busy;
  logic        stall_Id;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_Ex (start_Ex),
    .mdOp_Ex  (mdOp_Ex),
    .rs_Ex    (rs_Ex),
    .rt_Ex    (rt_Ex),
    .useMd_Id (useMd_Id),
    .busy     (busy),
    .stall_Id (stall_Id),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what HI/LO hold after the given operation completes.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      OP_MULTU: begin
        p = 64'(a) * 64'(b);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      OP_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      OP_DIVU: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_Ex = 1'b0;
    tick();
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
  endtask

  // Issue a mult/div in the current (idle) cycle and follow it to completion.
  // Returns in the first idle cycle after completion, without advancing.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_md, input logic poke);
    int n_exp;
    int cycles;
    n_exp = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
    start_Ex = 1'b1;
    mdOp_Ex  = op;
    rs_Ex    = a;
    rt_Ex    = b;
    useMd_Id = use_md;
    #1;
    check("stall_start", 64'(stall_Id), 64'(use_md));
    tick();
    model_apply(op, a, b);
    start_Ex = 1'b0;
    rs_Ex = $urandom;
    rt_Ex = $urandom;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      if (poke && cycles == 2) begin
        start_Ex = 1'b1;
        mdOp_Ex  = 3'($urandom_range(0, 3));
        rs_Ex    = $urandom;
        rt_Ex    = $urandom;
      end else begin
        start_Ex = 1'b0;
      end
      #1;
      check("stall_busy", 64'(stall_Id), 64'(use_md));
      check("done_busy", 64'(done), 64'd0);
      tick();
    end
    start_Ex = 1'b0;
    #1;
    check("busy_len", 64'(cycles), 64'(n_exp));
    check("done_pulse", 64'(done), 64'd1);
    check("hi_result", 64'(hi), 64'(hi_m));
    check("lo_result", 64'(lo), 64'(lo_m));
    check("stall_after", 64'(stall_Id), 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    start_Ex = 1'b1;
    mdOp_Ex  = op;
    rs_Ex    = a;
    rt_Ex    = $urandom;
    useMd_Id = 1'b1;
    #1;
    check("stall_mt", 64'(stall_Id), 64'd0);
    tick();
    model_apply(op, a, 32'd0);
    start_Ex = 1'b0;
    check("busy_mt", 64'(busy), 64'd0);
    check("done_mt", 64'(done), 64'd0);
    check("hi_mt", 64'(hi), 64'(hi_m));
    check("lo_mt", 64'(lo), 64'(lo_m));
  endtask

  initial begin
    reset    = 1'b1;
    start_Ex = 1'b0;
    mdOp_Ex  = '0;
    rs_Ex    = '0;
    rt_Ex    = '0;
    useMd_Id = 1'b0;
    hi_m     = '0;
    lo_m     = '0;
    tick();
    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    // Signed multiply with stall from an mfhi in ID.
    run_op(OP_MULT, 32'd3, 32'hFFFFFFFE, 1'b1, 1'b0);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFFA);
    tick();
    check("done_cleared", 64'(done), 64'd0);

    run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_lo", 64'(lo), 64'h3);
    check("divu_hi", 64'(hi), 64'h1);
    // Back-to-back: start in the first idle cycle.
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_hi", 64'(hi), 64'hFFFFFFFF);
    tick();

    // Divide by zero keeps HI/LO.
    run_mt(OP_MTHI, 32'h11);
    run_mt(OP_MTLO, 32'h22);
    run_op(OP_DIV, 32'h1234, 32'd0, 1'b1, 1'b0);
    check("dz_hi", 64'(hi), 64'h11);
    check("dz_lo", 64'(lo), 64'h22);
    tick();

    // Reset in busy cycle 4 of a DIV aborts with no done.
    start_Ex = 1'b1;
    mdOp_Ex  = OP_DIV;
    rs_Ex    = 32'd100;
    rt_Ex    = 32'd7;
    tick();
    start_Ex = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    for (int i = 0; i < DC; i++) begin
      check("abort_nodone", 64'(done), 64'd0);
      tick();
    end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFFFFFE);
    tick();

    // Reset wins over a start in the same cycle.
    reset    = 1'b1;
    start_Ex = 1'b1;
    mdOp_Ex  = OP_MULT;
    tick();
    reset    = 1'b0;
    start_Ex = 1'b0;
    hi_m = '0;
    lo_m = '0;
    check("rst_prio_busy", 64'(busy), 64'd0);

    // Start pulsed mid-operation is ignored.
    run_op(OP_DIVU, 32'd1000, 32'd33, 1'b1, 1'b1);
    check("poke_lo", 64'(lo), 64'd30);
    check("poke_hi", 64'(hi), 64'd10);
    tick();

    // Randomized mix.
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (op == OP_MTHI || op == OP_MTLO)
        run_mt(op, a);
      else
        run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = 0; g < $urandom_range(0, 2); g++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
